abs16_rr_sched: RTL



---
 rtl/abs16_rr_sched.sv | 119 +++++++++++
 1 files changed

// File: rtl/abs16_rr_sched.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : abs16_rr_sched (with helper abs16)
// Brief    : Round-robin share of one 16-bit absolute-value unit between NREQ
//            valid/ready requesters, with a single registered output stage.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------

module abs16 (
   input  logic [15:0] a,
   output logic [15:0] mag,
   output logic        ovf
);
   assign mag = (a ^ {16{a[15]}}) + {15'd0, a[15]};
   assign ovf = (a == 16'h8000);
endmodule

module abs16_rr_sched #(
   parameter int NREQ = 4,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [16*NREQ-1:0]   req_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [15:0]          out_data,
   output logic [IDW-1:0]       out_id,
   output logic                 out_ovf
);

   logic [IDW-1:0] r_ptr;
   logic           r_outValid;
   logic [15:0]    r_outData;
   logic [IDW-1:0] r_outId;
   logic           r_outOvf;

   logic           w_en;
   logic           w_xfer;
   logic           w_hiValid;
   logic           w_loValid;
   logic [IDW-1:0] w_hiIdx;
   logic [IDW-1:0] w_loIdx;
   logic [IDW-1:0] w_grantIdx;
   logic [15:0]    w_operand;
   logic [15:0]    w_mag;
   logic           w_ovf;

   // Lowest valid index at/above ptr wins; otherwise wrap to lowest valid overall.
   always_comb begin
      w_hiValid = 1'b0;
      w_loValid = 1'b0;
      w_hiIdx   = '0;
      w_loIdx   = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (req_valid[i]) begin
            w_loValid = 1'b1;
            w_loIdx   = IDW'(i);
            if (i >= int'(r_ptr)) begin
               w_hiValid = 1'b1;
               w_hiIdx   = IDW'(i);
            end
         end
      end
   end

   assign w_grantIdx = w_hiValid ? w_hiIdx : w_loIdx;
   assign w_en       = !r_outValid | out_ready;
   // Gated by rst so no requester believes an operand was taken during reset.
   assign w_xfer     = w_en & w_loValid & !rst;

   always_comb begin
      w_operand = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (w_grantIdx == IDW'(i)) begin
            w_operand = req_data[16*i +: 16];
         end
      end
   end

   abs16 u_abs (
      .a   (w_operand),
      .mag (w_mag),
      .ovf (w_ovf)
   );

   generate
      for (genvar gi = 0; gi < NREQ; gi++) begin : g_ready
         assign req_ready[gi] = w_xfer & (w_grantIdx == IDW'(gi));
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ptr      <= '0;
         r_outValid <= 1'b0;
         r_outData  <= '0;
         r_outId    <= '0;
         r_outOvf   <= 1'b0;
      end else if (w_xfer) begin
         r_outValid <= 1'b1;
         r_outData  <= w_mag;
         r_outId    <= w_grantIdx;
         r_outOvf   <= w_ovf;
         r_ptr      <= (w_grantIdx == IDW'(NREQ - 1)) ? '0 : w_grantIdx + IDW'(1);
      end else if (out_ready) begin
         r_outValid <= 1'b0;
      end
   end

   assign out_valid = r_outValid;
   assign out_data  = r_outData;
   assign out_id    = r_outId;
   assign out_ovf   = r_outOvf;

endmodule
`default_nettype wire
